// File: rtl/blood_pkg.sv
// blood_pkg: shared types and constants for the blood-splatter sprite renderer
//   state_t     : animation FSM states
//   SPRITE_W    : sprite edge length in texels
//   SPRITE_AW   : ROM row/col address width
//   TRANSPARENT : color key treated as "no pixel"
//   dim()       : halves each 4-bit channel of a 12-bit color
package blood_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, SHOW} state_t;
    localparam int SPRITE_W = 64;
    localparam int SPRITE_AW = 6;
    localparam logic [11:0] TRANSPARENT = 12'h000;
    function automatic logic [11:0] dim(input logic [11:0] c);
        return (c >> 1) & 12'h777;
    endfunction
endpackage

// File: rtl/blood_anim_fsm.sv
// blood_anim_fsm: hit/frame sequencing, frame counter and pending/shadow sprite position
//   in : clk, reset (async, active-high), frame_tick, hit, hit_x, hit_y
//   out: draw_en, fade, busy, shadow_x, shadow_y
//   BLOOD_FADE_EN: when defined, fade asserts for the last quarter of DURATION
module blood_anim_fsm
    import blood_pkg::*;
#(
    parameter int DURATION = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       hit,
    input  logic [9:0] hit_x,
    input  logic [9:0] hit_y,
    output logic       draw_en,
    output logic       fade,
    output logic       busy,
    output logic [9:0] shadow_x,
    output logic [9:0] shadow_y
);
    localparam int CW = DURATION > 1 ? $clog2(DURATION) : 1;
    localparam logic [CW-1:0] LAST = CW'(DURATION - 1);
    state_t state;
    logic from_show;
    logic [CW-1:0] frame_cnt;
    logic [9:0] pend_x, pend_y;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            from_show <= 1'b0;
            frame_cnt <= '0;
            pend_x    <= '0;
            pend_y    <= '0;
            shadow_x  <= '0;
            shadow_y  <= '0;
        end else begin
            case (state)
                IDLE: if (hit) begin
                    pend_x    <= hit_x;
                    pend_y    <= hit_y;
                    from_show <= 1'b0;
                    state     <= ARMED;
                end
                ARMED: if (frame_tick) begin
                    // a hit coinciding with the tick is newer than pend, so it wins
                    shadow_x  <= hit ? hit_x : pend_x;
                    shadow_y  <= hit ? hit_y : pend_y;
                    frame_cnt <= '0;
                    from_show <= 1'b0;
                    state     <= SHOW;
                end else if (hit) begin
                    pend_x <= hit_x;
                    pend_y <= hit_y;
                end
                SHOW: if (hit) begin
                    // old splatter keeps drawing from shadow until the next tick
                    pend_x    <= hit_x;
                    pend_y    <= hit_y;
                    from_show <= 1'b1;
                    state     <= ARMED;
                end else if (frame_tick) begin
                    if (frame_cnt == LAST) state <= IDLE;
                    else frame_cnt <= frame_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign draw_en = (state == SHOW) | ((state == ARMED) & from_show);
    assign busy = state != IDLE;
`ifdef BLOOD_FADE_EN
    assign fade = int'(frame_cnt) >= DURATION - DURATION / 4;
`else
    assign fade = 1'b0;
`endif
endmodule

// File: rtl/blood_sprite_render.sv
// blood_sprite_render: maps VGA x/y onto the 64x64 splatter ROM and emits keyed, aligned pixels
//   in : clk, reset (async, active-high), x, y, video_on, frame_tick, hit, hit_x, hit_y, rom_data
//   out: rom_row, rom_col (combinational), blood_on, rgb (registered, 2 clk after x/y), busy
//   BLOOD_FADE_EN: when defined, rgb channels are halved during the last quarter of DURATION
module blood_sprite_render
    import blood_pkg::*;
#(
    parameter int DURATION = 30,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        video_on,
    input  logic        frame_tick,
    input  logic        hit,
    input  logic [9:0]  hit_x,
    input  logic [9:0]  hit_y,
    output logic [5:0]  rom_row,
    output logic [5:0]  rom_col,
    input  logic [11:0] rom_data,
    output logic        blood_on,
    output logic [11:0] rgb,
    output logic        busy
);
    localparam logic [10:0] HA = 11'(H_ACTIVE);
    localparam logic [10:0] VA = 11'(V_ACTIVE);
    logic draw_en, fade, in_box, in_box_d1, blood_on_next;
    logic [9:0] shadow_x, shadow_y;
    logic [10:0] dx, dy;
    blood_anim_fsm #(.DURATION(DURATION)) u_fsm (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .hit(hit),
        .hit_x(hit_x), .hit_y(hit_y), .draw_en(draw_en), .fade(fade),
        .busy(busy), .shadow_x(shadow_x), .shadow_y(shadow_y)
    );
    // 11-bit unsigned differences: pixels left/above the box go negative and fail the high-bit test
    assign dx = {1'b0, x} - {1'b0, shadow_x};
    assign dy = {1'b0, y} - {1'b0, shadow_y};
    assign in_box = draw_en & video_on & ({1'b0, x} < HA) & ({1'b0, y} < VA)
                  & (dx[10:SPRITE_AW] == '0) & (dy[10:SPRITE_AW] == '0);
    assign rom_row = dy[SPRITE_AW-1:0];
    assign rom_col = dx[SPRITE_AW-1:0];
    assign blood_on_next = in_box_d1 & (rom_data != TRANSPARENT);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_box_d1 <= 1'b0;
            blood_on  <= 1'b0;
            rgb       <= '0;
        end else begin
            in_box_d1 <= in_box;
            blood_on  <= blood_on_next;
            rgb       <= blood_on_next ? (fade ? dim(rom_data) : rom_data) : TRANSPARENT;
        end
    end
endmodule

// File: tb/tb_blood_sprite_render.sv
// tb_blood_sprite_render: directed self-checking bench for blood_sprite_render with a modelled sprite ROM
module tb_blood_sprite_render;
`ifdef BLOOD_FADE_EN
    localparam int D = 8;
`else
    localparam int D = 3;
`endif
    localparam int FS = D - D / 4;

    typedef struct {
        logic [9:0]  x, y;
        logic        vid, addr;
        logic [5:0]  row, col;
        logic        on;
        logic [11:0] rgb;
    } vec_t;

    logic clk = 0, reset = 1, video_on = 0, frame_tick = 0, hit = 0;
    logic [9:0] x = 0, y = 0, hit_x = 0, hit_y = 0;
    logic [5:0] rom_row, rom_col;
    logic [11:0] rom_data = 0, rgb;
    logic blood_on, busy;
    int n_chk = 0, n_pass = 0;
    vec_t vt[12];

    function automatic logic [11:0] tex(input logic [5:0] r, input logic [5:0] c);
        return ((int'(r) + int'(c)) % 5 == 0) ? 12'h000 : {r, c};
    endfunction

    function automatic logic [12:0] model(input int px, input int py, input int sx, input int sy);
        logic [11:0] t;
        if (px < sx || px > sx + 63 || py < sy || py > sy + 63 || px >= 640 || py >= 480) return 13'h0;
        t = tex(6'(py - sy), 6'(px - sx));
        return {t != 12'h000, t};
    endfunction

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= tex(rom_row, rom_col);

    blood_sprite_render #(.DURATION(D)) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .video_on(video_on),
        .frame_tick(frame_tick), .hit(hit), .hit_x(hit_x), .hit_y(hit_y),
        .rom_row(rom_row), .rom_col(rom_col), .rom_data(rom_data),
        .blood_on(blood_on), .rgb(rgb), .busy(busy)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic px(input string nm, input int px_, input int py_, input logic on, input logic [11:0] c);
        x = 10'(px_);
        y = 10'(py_);
        video_on = 1;
        step(2);
        chk({nm, "_on"}, 32'(blood_on), 32'(on));
        chk({nm, "_rgb"}, 32'(rgb), 32'(c));
    endtask

    task automatic tick();
        frame_tick = 1;
        step(1);
        frame_tick = 0;
    endtask

    task automatic do_hit(input int hx, input int hy, input logic with_tick);
        hit = 1;
        hit_x = 10'(hx);
        hit_y = 10'(hy);
        frame_tick = with_tick;
        step(1);
        hit = 0;
        frame_tick = 0;
    endtask

    initial begin
        vt[0]  = '{10'd100, 10'd50,  1'b1, 1'b1, 6'd0,  6'd0,  1'b0, 12'h000};
        vt[1]  = '{10'd101, 10'd50,  1'b1, 1'b1, 6'd0,  6'd1,  1'b1, 12'h001};
        vt[2]  = '{10'd163, 10'd113, 1'b1, 1'b1, 6'd63, 6'd63, 1'b1, 12'hFFF};
        vt[3]  = '{10'd99,  10'd50,  1'b1, 1'b0, 6'd0,  6'd0,  1'b0, 12'h000};
        vt[4]  = '{10'd164, 10'd50,  1'b1, 1'b0, 6'd0,  6'd0,  1'b0, 12'h000};
        vt[5]  = '{10'd100, 10'd49,  1'b1, 1'b0, 6'd0,  6'd0,  1'b0, 12'h000};
        vt[6]  = '{10'd100, 10'd114, 1'b1, 1'b0, 6'd0,  6'd0,  1'b0, 12'h000};
        vt[7]  = '{10'd110, 10'd60,  1'b1, 1'b1, 6'd10, 6'd10, 1'b0, 12'h000};
        vt[8]  = '{10'd130, 10'd71,  1'b1, 1'b1, 6'd21, 6'd30, 1'b1, 12'h55E};
        vt[9]  = '{10'd151, 10'd90,  1'b1, 1'b1, 6'd40, 6'd51, 1'b1, 12'hA33};
        vt[10] = '{10'd150, 10'd90,  1'b1, 1'b1, 6'd40, 6'd50, 1'b0, 12'h000};
        vt[11] = '{10'd120, 10'd50,  1'b0, 1'b1, 6'd0,  6'd20, 1'b0, 12'h000};

        step(2);
        chk("rst_on", 32'(blood_on), 0);
        chk("rst_rgb", 32'(rgb), 0);
        chk("rst_busy", 32'(busy), 0);
        reset = 0;
        step(1);

        for (int yy = 0; yy < 480; yy += 60)
            for (int xx = 0; xx < 640; xx += 80) px("idle_px", xx, yy, 0, 12'h000);
        tick();
        chk("idle_busy", 32'(busy), 0);

        do_hit(100, 50, 0);
        chk("armed_busy", 32'(busy), 1);
        px("armed_nodraw", 101, 51, 0, 12'h000);
        tick();

        for (int i = 0; i < 12; i++) begin
            x = vt[i].x;
            y = vt[i].y;
            video_on = vt[i].vid;
            #1;
            if (vt[i].addr) begin
                chk($sformatf("vec%0d_row", i), 32'(rom_row), 32'(vt[i].row));
                chk($sformatf("vec%0d_col", i), 32'(rom_col), 32'(vt[i].col));
            end
            step(2);
            chk($sformatf("vec%0d_on", i), 32'(blood_on), 32'(vt[i].on));
            chk($sformatf("vec%0d_rgb", i), 32'(rgb), 32'(vt[i].rgb));
        end

        video_on = 1;
        y = 51;
        for (int i = 0; i < 16; i++) begin
            x = 10'(96 + i);
            step(1);
            if (i > 0) chk($sformatf("stream_x%0d", 95 + i), 32'({blood_on, rgb}), 32'(model(95 + i, 51, 100, 50)));
        end

        for (int f = 0; f < D; f++) begin
            px($sformatf("dur_f%0d", f), 163, 113, 1, f >= FS ? 12'h777 : 12'hFFF);
            chk($sformatf("dur_busy_f%0d", f), 32'(busy), 1);
            tick();
        end
        chk("expired_busy", 32'(busy), 0);
        px("expired_px", 163, 113, 0, 12'h000);

        do_hit(600, 440, 0);
        tick();
        x = 639;
        y = 479;
        #1;
        chk("clip_row", 32'(rom_row), 39);
        chk("clip_col", 32'(rom_col), 39);
        px("clip_corner", 639, 479, 1, 12'h9E7);
        px("clip_h", 640, 479, 0, 12'h000);
        px("nowrap_00", 0, 0, 0, 12'h000);
        px("nowrap_x", 23, 479, 0, 12'h000);
        px("nowrap_y", 639, 15, 0, 12'h000);

        tick();
        do_hit(10, 10, 1);
        chk("retrig_busy", 32'(busy), 1);
        px("retrig_old", 639, 479, 1, 12'h9E7);
        px("retrig_new_wait", 11, 10, 0, 12'h000);
        tick();
        px("retrig_old_gone", 639, 479, 0, 12'h000);
        for (int f = 0; f < D; f++) begin
            px($sformatf("retrig_f%0d", f), 11, 10, 1, f >= FS ? 12'h000 : 12'h001);
            chk($sformatf("retrig_busy_f%0d", f), 32'(busy), 1);
            tick();
        end
        chk("retrig_end_busy", 32'(busy), 0);

        do_hit(200, 200, 0);
        tick();
        px("pre_rst", 201, 200, 1, 12'h001);
        reset = 1;
        #1;
        chk("async_rst_on", 32'(blood_on), 0);
        chk("async_rst_rgb", 32'(rgb), 0);
        chk("async_rst_busy", 32'(busy), 0);
        step(2);
        reset = 0;
        px("post_rst", 201, 200, 0, 12'h000);
        tick();
        chk("post_rst_busy", 32'(busy), 0);
        px("post_rst_tick", 201, 200, 0, 12'h000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
